// File: rtl/stream_mux2to1_rr.sv
// stream_mux2to1_rr: registered 2:1 valid/ready stream merge with round-robin arbitration
//   clk, rst             : clock, synchronous active-high reset
//   i0_* / i1_*          : input streams (data, valid, ready)
//   y_data/y_sel/y_valid : registered output word, its source tag and valid
//   y_ready              : consumer accepts the output word
module stream_mux2to1_rr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0_data,
   input  logic             i0_valid,
   output logic             i0_ready,
   input  logic [WIDTH-1:0] i1_data,
   input  logic             i1_valid,
   output logic             i1_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_sel,
   output logic             y_valid,
   input  logic             y_ready
);
   logic prio, load, any, g;
   always_comb begin
      load     = ~y_valid | y_ready;
      any      = i0_valid | i1_valid;
      g        = (i0_valid & i1_valid) ? prio : i1_valid;
      i0_ready = load & any & ~g & ~rst;
      i1_ready = load & any & g & ~rst;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_sel   <= 1'b0;
         prio    <= 1'b0;
      end else if (load) begin
         y_valid <= any;
         if (any) begin
            y_data <= g ? i1_data : i0_data;
            y_sel  <= g;
            prio   <= ~g;
         end
      end
   end
endmodule
